mem_bus_arbiter: RTL

//  Arbitrates the single-ported system memory (RAM low, ROM high) between the 6502 core
//  and a debug/loader port used by benches to preload and inspect RAM.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_prio.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory bus arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  localparam logic [15:0] ROM_BASE_DEFAULT = 16'hF000;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - requester pick; MEM_ARB_ROUND_ROBIN_EN adds the last-grant pointer
module mem_arb_prio
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
`endif
  input  logic cpu_elig,
  input  logic dbg_elig,
  output logic any_elig,
  output logic win_dbg
);

  assign any_elig = cpu_elig || dbg_elig;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // prio_q names the requester that wins the next tie, i.e. the one not granted last
  req_id_t prio_q, prio_d;

  assign win_dbg = dbg_elig && (!cpu_elig || (prio_q == REQ_DBG));

  always_comb begin
    prio_d = prio_q;
    if (grant_en && any_elig) begin
      prio_d = win_dbg ? REQ_CPU : REQ_DBG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= REQ_CPU;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign win_dbg = dbg_elig && !cpu_elig;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/debug arbiter for the single-ported RAM/ROM memory
// Tie policy: fixed CPU priority, or round robin when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] ROM_BASE = ROM_BASE_DEFAULT
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rom_wr_err
);

  arb_state_t        state_q, state_d;
  req_id_t           id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic grant_en, any_elig, win_dbg, rom_hit;
  logic cpu_elig, dbg_elig;
  logic [DATA_W-1:0] rsp_data;

  // The port being acked still holds req during RESP; it must not win again.
  assign cpu_elig = cpu_req && !((state_q == RESP) && (id_q == REQ_CPU));
  assign dbg_elig = dbg_req && !((state_q == RESP) && (id_q == REQ_DBG));
  assign grant_en = (state_q == IDLE) || (state_q == RESP);
  assign rom_hit  = (addr_q >= ROM_BASE);

  mem_arb_prio u_prio (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk      (ph1),
    .rst      (reset),
    .grant_en (grant_en),
`endif
    .cpu_elig (cpu_elig),
    .dbg_elig (dbg_elig),
    .any_elig (any_elig),
    .win_dbg  (win_dbg)
  );

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE:    state_d = any_elig ? ISSUE : IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = any_elig ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
    if (grant_en && any_elig) begin
      id_d    = win_dbg ? REQ_DBG : REQ_CPU;
      we_d    = win_dbg ? dbg_we : cpu_we;
      addr_d  = win_dbg ? dbg_addr : cpu_addr;
      wdata_d = win_dbg ? dbg_wdata : cpu_wdata;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    cpu_rdata  = '0;
    dbg_rdata  = '0;
    rom_wr_err = 1'b0;
    rsp_data   = we_q ? '0 : mem_rdata;
    case (state_q)
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = we_q && !rom_hit;
      end
      RESP: begin
        rom_wr_err = we_q && rom_hit;
        if (id_q == REQ_CPU) begin
          cpu_ack   = 1'b1;
          cpu_rdata = rsp_data;
        end else begin
          dbg_ack   = 1'b1;
          dbg_rdata = rsp_data;
        end
      end
      default: ;
    endcase
  end

endmodule
